tile_coord_buffer: RTL

- Sits directly downstream of the pipelined tile-index divider; captures each result (quotient = tile row, remainder = tile column, k tag) on its res_rdy strobe.
- The divider has no backpressure, so this block provides the elastic buffering between it and the stalling PE-dispatch consumer.
- Range-checks coordinates, marks the final tile of each (Ht x Wt) plane, and raises almost_full early enough to throttle divider issue.

---
 rtl/tile_coord_buffer_pkg.sv | 33 +++
 rtl/tile_coord_buffer_fifo_mem.sv | 67 ++++++
 rtl/tile_coord_buffer.sv | 108 ++++++++++
 3 files changed

// File: rtl/tile_coord_buffer_pkg.sv
// Shared widths, the buffered tile-coordinate entry type and the almost-full threshold helper.
// Widths follow the divider: quotient = tile row, remainder = tile column.
`ifndef max_num_Wt
`define max_num_Wt 4
`endif
`ifndef max_num_Ht
`define max_num_Ht 4
`endif
`ifndef max_num_K
`define max_num_K 16
`endif

package tile_coord_buffer_pkg;

    localparam int QW = $clog2(`max_num_Wt * `max_num_Ht);
    localparam int RW = $clog2(`max_num_Wt) + 1;
    localparam int KW = $clog2(`max_num_K) + 1;

    typedef struct packed {
        logic [QW-1:0] row;
        logic [RW-1:0] col;
        logic [KW-1:0] k;
        logic          last;
        logic          err;
    } tile_coord_t;

    // A margin at or above the depth would give a threshold of zero or less, which would assert
    // almost_full on an empty buffer; one entry is the lowest useful threshold.
    function automatic int af_threshold(input int depth, input int margin);
        return ((depth - margin) < 1) ? 1 : (depth - margin);
    endfunction

endpackage

// File: rtl/tile_coord_buffer_fifo_mem.sv
// Generic DEPTH x W storage with wrapping pointers and an occupancy count; full/empty come from the count.
// Head data is read combinationally (fall-through); the parent only issues legal wr_en_i/rd_en_i.
module coord_fifo_mem #(
    parameter int W     = 8,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wr_en_i,
    input  logic [W-1:0]             wr_dat_i,
    input  logic                     rd_en_i,
    output logic [W-1:0]             rd_dat_o,
    output logic [$clog2(DEPTH):0]   count_o,
    output logic                     full_o,
    output logic                     empty_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (wr_en_i) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (rd_en_i) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        case ({wr_en_i, rd_en_i})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage is deliberately left out of reset; the count alone decides what is valid.
    always_ff @(posedge clk) begin
        if (wr_en_i) begin
            mem_q[wr_ptr_q] <= wr_dat_i;
        end
    end

    assign rd_dat_o = mem_q[rd_ptr_q];
    assign count_o  = count_q;
    assign full_o   = (count_q == CW'(DEPTH));
    assign empty_o  = (count_q == '0);

endmodule

// File: rtl/tile_coord_buffer.sv
// Elastic FWFT buffer behind the tile-index divider: range-checks and tags each result, 1-cycle write-to-out_valid.
// The divider cannot stall, so writes while full and not reading are dropped (sticky overflow); almost_full throttles issue early.
module tile_coord_buffer
    import tile_coord_buffer_pkg::*;
#(
    parameter int DEPTH     = 8,
    parameter int AF_MARGIN = QW + 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   res_rdy,
    input  logic [QW-1:0]          quotient,
    input  logic [RW-1:0]          remainder,
    input  logic [KW-1:0]          k_in,
    input  logic [RW-1:0]          num_Wt,
    input  logic [QW-1:0]          num_Ht,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [QW-1:0]          out_row,
    output logic [RW-1:0]          out_col,
    output logic [KW-1:0]          out_k,
    output logic                   out_last,
    output logic                   out_err,
    output logic                   almost_full,
    output logic                   overflow,
    output logic                   range_err,
    output logic [$clog2(DEPTH):0] count
);

    localparam int CW    = $clog2(DEPTH) + 1;
    localparam int AF_TH = af_threshold(DEPTH, AF_MARGIN);

    tile_coord_t   wr_ent;
    tile_coord_t   head;
    logic          last_c, err_c;
    logic          wr_en, rd_en, drop;
    logic          fifo_full, fifo_empty;
    logic [CW-1:0] fifo_count, count_nxt;

    logic          af_q, af_d;
    logic          overflow_q, overflow_d;
    logic          range_err_q, range_err_d;

    // With a zero dimension every coordinate fails the range check, and last must not fire via num-1 wrapping.
    always_comb begin
        err_c  = (remainder >= num_Wt) || (quotient >= num_Ht);
        last_c = (num_Wt != '0) && (num_Ht != '0)
              && (quotient == (num_Ht - QW'(1)))
              && (remainder == (num_Wt - RW'(1)));
        wr_ent = '{row: quotient, col: remainder, k: k_in, last: last_c, err: err_c};
    end

    assign rd_en = !fifo_empty && out_ready;
    assign wr_en = res_rdy && (!fifo_full || rd_en);
    assign drop  = res_rdy && !wr_en;

    coord_fifo_mem #(
        .W     ($bits(tile_coord_t)),
        .DEPTH (DEPTH)
    ) u_mem (
        .clk      (clk),
        .rst      (rst),
        .wr_en_i  (wr_en),
        .wr_dat_i (wr_ent),
        .rd_en_i  (rd_en),
        .rd_dat_o (head),
        .count_o  (fifo_count),
        .full_o   (fifo_full),
        .empty_o  (fifo_empty)
    );

    always_comb begin
        count_nxt = fifo_count;
        case ({wr_en, rd_en})
            2'b10:   count_nxt = fifo_count + CW'(1);
            2'b01:   count_nxt = fifo_count - CW'(1);
            default: count_nxt = fifo_count;
        endcase
        af_d        = (count_nxt >= CW'(AF_TH));
        overflow_d  = overflow_q | drop;
        range_err_d = range_err_q | (wr_en & err_c);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            af_q        <= 1'b0;
            overflow_q  <= 1'b0;
            range_err_q <= 1'b0;
        end else begin
            af_q        <= af_d;
            overflow_q  <= overflow_d;
            range_err_q <= range_err_d;
        end
    end

    // Head fields are masked while empty so unreset storage never shows on the outputs.
    assign out_valid   = !fifo_empty;
    assign out_row     = out_valid ? head.row  : '0;
    assign out_col     = out_valid ? head.col  : '0;
    assign out_k       = out_valid ? head.k    : '0;
    assign out_last    = out_valid ? head.last : 1'b0;
    assign out_err     = out_valid ? head.err  : 1'b0;
    assign almost_full = af_q;
    assign overflow    = overflow_q;
    assign range_err   = range_err_q;
    assign count       = fifo_count;

endmodule
